// File: rtl/acq_search_ctrl.sv
// Acquisition search controller: sweeps a grid of (doppler bin, code shift) cells
// on one tracking channel. For each cell it seeks the code, feeds one accumulation,
// reads the prompt power, and keeps the strongest cell seen.
// Ports: clk/global_reset (sync, active-high); start/abort control pulses;
//   prn_in, doppler_start/step/bins, code_step/max, threshold search parameters;
//   code_shift, accumulation_complete, i2q2_valid/prompt from the channel;
//   mode, prn, doppler, seek_en/seek_target, feed_en to the channel;
//   busy, done, found, best_power/doppler/code status. All outputs registered.
module acq_search_ctrl #(
   parameter int DW    = 16,
   parameter int CSW   = 11,
   parameter int I2Q2W = 32,
   parameter int BW    = 6
) (
   input  logic             clk,
   input  logic             global_reset,
   input  logic             start,
   input  logic             abort,
   input  logic [4:0]       prn_in,
   input  logic [DW-1:0]    doppler_start,
   input  logic [DW-1:0]    doppler_step,
   input  logic [BW-1:0]    doppler_bins,
   input  logic [CSW-1:0]   code_step,
   input  logic [CSW-1:0]   code_max,
   input  logic [I2Q2W-1:0] threshold,
   input  logic [CSW-1:0]   code_shift,
   input  logic             accumulation_complete,
   input  logic             i2q2_valid,
   input  logic [I2Q2W-1:0] i2q2_prompt,
   output logic [1:0]       mode,
   output logic [4:0]       prn,
   output logic [DW-1:0]    doppler,
   output logic             seek_en,
   output logic [CSW-1:0]   seek_target,
   output logic             feed_en,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [I2Q2W-1:0] best_power,
   output logic [DW-1:0]    best_doppler,
   output logic [CSW-1:0]   best_code
);

   localparam logic [1:0] MODE_TRACK = 2'b00;
   localparam logic [1:0] MODE_ACQ   = 2'b01;

   typedef enum logic [2:0] {
      IDLE, SEEK, WAIT_SEEK, ACCUM, WAIT_PWR, ADVANCE, DONE
   } state_t;

   state_t           state;
   logic [CSW-1:0]   code;
   logic [BW-1:0]    bin;
   logic [CSW-1:0]   code_step_r;
   logic [CSW-1:0]   code_max_r;
   logic [DW-1:0]    doppler_step_r;
   logic [BW-1:0]    bins_r;
   logic [I2Q2W-1:0] threshold_r;

   // One extra bit so code + step never wraps before the compare with code_max.
   logic [CSW:0]     code_next;
   logic             code_wrap;
   logic [BW:0]      bin_next;
   logic             last_bin;

   assign code_next = {1'b0, code} + {1'b0, code_step_r};
   assign code_wrap = code_next > {1'b0, code_max_r};
   assign bin_next  = {1'b0, bin} + {{BW{1'b0}}, 1'b1};
   assign last_bin  = bin_next == {1'b0, bins_r};

   always_ff @(posedge clk) begin
      if (global_reset) begin
         state          <= IDLE;
         mode           <= MODE_TRACK;
         prn            <= '0;
         doppler        <= '0;
         seek_en        <= 1'b0;
         seek_target    <= '0;
         feed_en        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         found          <= 1'b0;
         best_power     <= '0;
         best_doppler   <= '0;
         best_code      <= '0;
         code           <= '0;
         bin            <= '0;
         code_step_r    <= '0;
         code_max_r     <= '0;
         doppler_step_r <= '0;
         bins_r         <= '0;
         threshold_r    <= '0;
      end else if (abort && state != IDLE) begin
         // Abort wins over any channel handshake arriving in the same cycle.
         state   <= IDLE;
         mode    <= MODE_TRACK;
         seek_en <= 1'b0;
         feed_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         found   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  prn            <= prn_in;
                  doppler        <= doppler_start;
                  doppler_step_r <= doppler_step;
                  bins_r         <= (doppler_bins == '0) ? {{(BW-1){1'b0}}, 1'b1} : doppler_bins;
                  code_step_r    <= (code_step == '0) ? {{(CSW-1){1'b0}}, 1'b1} : code_step;
                  code_max_r     <= code_max;
                  threshold_r    <= threshold;
                  code           <= '0;
                  bin            <= '0;
                  best_power     <= '0;
                  best_doppler   <= doppler_start;
                  best_code      <= '0;
                  found          <= 1'b0;
                  busy           <= 1'b1;
                  mode           <= MODE_ACQ;
                  seek_en        <= 1'b1;
                  seek_target    <= '0;
                  state          <= SEEK;
               end
            end
            SEEK: begin
               seek_en <= 1'b0;
               state   <= WAIT_SEEK;
            end
            WAIT_SEEK: begin
               if (code_shift == code) begin
                  feed_en <= 1'b1;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (accumulation_complete) begin
                  feed_en <= 1'b0;
                  state   <= WAIT_PWR;
               end
            end
            WAIT_PWR: begin
               if (i2q2_valid) begin
                  // Strict compare: on a tie the earlier cell is kept.
                  if (i2q2_prompt > best_power) begin
                     best_power   <= i2q2_prompt;
                     best_doppler <= doppler;
                     best_code    <= code;
                  end
                  state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (code_wrap) begin
                  code    <= '0;
                  bin     <= bin_next[BW-1:0];
                  doppler <= doppler + doppler_step_r;
                  if (last_bin) begin
                     done  <= 1'b1;
                     found <= best_power > threshold_r;
                     state <= DONE;
                  end else begin
                     seek_en     <= 1'b1;
                     seek_target <= '0;
                     state       <= SEEK;
                  end
               end else begin
                  code        <= code_next[CSW-1:0];
                  seek_en     <= 1'b1;
                  seek_target <= code_next[CSW-1:0];
                  state       <= SEEK;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               mode  <= MODE_TRACK;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acq_search_ctrl.sv
module tb_acq_search_ctrl;
   localparam int DW = 16, CSW = 11, I2Q2W = 32, BW = 6;
   localparam logic [1:0] MODE_TRACK = 2'b00;

   logic clk, global_reset, start, abort;
   logic [4:0] prn_in;
   logic [DW-1:0] doppler_start, doppler_step;
   logic [BW-1:0] doppler_bins;
   logic [CSW-1:0] code_step, code_max, code_shift;
   logic [I2Q2W-1:0] threshold, i2q2_prompt;
   logic accumulation_complete, i2q2_valid;
   logic [1:0] mode;
   logic [4:0] prn;
   logic [DW-1:0] doppler, best_doppler;
   logic seek_en, feed_en, busy, done, found;
   logic [CSW-1:0] seek_target, best_code;
   logic [I2Q2W-1:0] best_power;

   int checks = 0;
   int errors = 0;

   // channel model configuration
   logic r_valid, m_valid, hold_pwr;
   logic [I2Q2W-1:0] r_pwr, m_pwr, hit_pwr, def_pwr;
   logic [CSW-1:0] hit_code;
   logic [DW-1:0] hit_dop;
   assign i2q2_valid  = r_valid | m_valid;
   assign i2q2_prompt = m_valid ? m_pwr : r_pwr;

   logic [CSW-1:0] log_tgt [0:63];
   logic [DW-1:0]  log_dop [0:63];
   int seek_cnt = 0;
   int rstate = 0;
   int rcnt = 0;
   logic [CSW-1:0] r_tgt;
   logic [DW-1:0]  r_dop;

   acq_search_ctrl #(.DW(DW), .CSW(CSW), .I2Q2W(I2Q2W), .BW(BW)) dut (
      .clk(clk), .global_reset(global_reset), .start(start), .abort(abort),
      .prn_in(prn_in), .doppler_start(doppler_start), .doppler_step(doppler_step),
      .doppler_bins(doppler_bins), .code_step(code_step), .code_max(code_max),
      .threshold(threshold), .code_shift(code_shift),
      .accumulation_complete(accumulation_complete), .i2q2_valid(i2q2_valid),
      .i2q2_prompt(i2q2_prompt), .mode(mode), .prn(prn), .doppler(doppler),
      .seek_en(seek_en), .seek_target(seek_target), .feed_en(feed_en),
      .busy(busy), .done(done), .found(found), .best_power(best_power),
      .best_doppler(best_doppler), .best_code(best_code));

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Channel responder: logs each seek, then answers with code_shift,
   // accumulation_complete and one power sample after fixed delays.
   initial begin
      code_shift = '0; accumulation_complete = 0; r_valid = 0; r_pwr = '0;
      forever begin
         @(negedge clk);
         accumulation_complete = 0;
         r_valid = 0;
         if (seek_en === 1'b1) begin
            if (seek_cnt < 64) begin
               log_tgt[seek_cnt] = seek_target;
               log_dop[seek_cnt] = doppler;
            end
            seek_cnt++;
            r_tgt = seek_target; r_dop = doppler; rstate = 1; rcnt = 0;
         end else begin
            case (rstate)
               1: begin rcnt++; if (rcnt >= 2) begin code_shift = r_tgt; rstate = 2; end end
               2: if (feed_en === 1'b1) begin rstate = 3; rcnt = 0; end
               3: begin rcnt++; if (rcnt >= 3) begin accumulation_complete = 1; rstate = 4; end end
               4: if (feed_en === 1'b0) begin rstate = 5; rcnt = 0; end
               5: begin
                  rcnt++;
                  if (rcnt >= 2) begin
                     if (!hold_pwr) begin
                        r_valid = 1;
                        r_pwr = (r_tgt == hit_code && r_dop == hit_dop) ? hit_pwr : def_pwr;
                     end
                     rstate = 0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   task automatic run_search(input int restart_at, output int dcnt, output int base);
      bit fin;
      base = seek_cnt; dcnt = 0; fin = 0;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
      for (int i = 0; i < 3000 && !fin; i++) begin
         start = (i == restart_at);
         @(negedge clk);
         if (done === 1'b1) dcnt++;
         if (busy !== 1'b1) fin = 1;
      end
      start = 0;
      checks++;
      if (!fin) begin errors++; $display("FAIL search_timeout busy still %b", busy); end
   endtask

   task automatic wait_feed(input logic lvl);
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (feed_en === lvl) begin ok = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL wait_feed got %b want %b", feed_en, lvl); end
   endtask

   task automatic check_seeks(input string nm, input int base, input int n,
                              input int et [6], input int ed [6]);
      logic [CSW-1:0] t;
      logic [DW-1:0] d;
      checks++;
      if (seek_cnt - base !== n) begin
         errors++; $display("FAIL %s seek_count got %0d want %0d", nm, seek_cnt - base, n);
      end
      for (int k = 0; k < n; k++) begin
         t = et[k][CSW-1:0];
         d = ed[k][DW-1:0];
         checks++;
         if (log_tgt[base+k] !== t || log_dop[base+k] !== d) begin
            errors++;
            $display("FAIL %s seek[%0d] target/doppler got %0d/%0d want %0d/%0d",
                     nm, k, log_tgt[base+k], $signed(log_dop[base+k]), t, $signed(d));
         end
      end
   endtask

   task automatic check_result(input string nm, input int dcnt, input logic f,
                               input logic [I2Q2W-1:0] bp, input logic [DW-1:0] bd,
                               input logic [CSW-1:0] bc);
      checks++;
      if (dcnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", nm, dcnt); end
      checks++;
      if (found !== f) begin errors++; $display("FAIL %s found got %b want %b", nm, found, f); end
      checks++;
      if (best_power !== bp) begin errors++; $display("FAIL %s best_power got %0d want %0d", nm, best_power, bp); end
      checks++;
      if (best_doppler !== bd) begin
         errors++; $display("FAIL %s best_doppler got %0d want %0d", nm, $signed(best_doppler), $signed(bd));
      end
      checks++;
      if (best_code !== bc) begin errors++; $display("FAIL %s best_code got %0d want %0d", nm, best_code, bc); end
      checks++;
      if (mode !== MODE_TRACK) begin errors++; $display("FAIL %s mode_after got %0d want %0d", nm, mode, MODE_TRACK); end
   endtask

   task automatic test_reset();
      global_reset = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 0 || done !== 0 || found !== 0 || seek_en !== 0 || feed_en !== 0) begin
         errors++; $display("FAIL reset_flags busy/done/found/seek/feed got %b%b%b%b%b want 00000",
                            busy, done, found, seek_en, feed_en);
      end
      checks++;
      if (mode !== MODE_TRACK) begin errors++; $display("FAIL reset_mode got %0d want %0d", mode, MODE_TRACK); end
      checks++;
      if (best_power !== 0 || best_code !== 0 || best_doppler !== 0 || seek_target !== 0 || prn !== 0 || doppler !== 0) begin
         errors++; $display("FAIL reset_values bp=%0d bc=%0d bd=%0d st=%0d prn=%0d dop=%0d want all 0",
                            best_power, best_code, best_doppler, seek_target, prn, doppler);
      end
      global_reset = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
   endtask

   task automatic test_main_search();
      int dcnt, base;
      int et [6] = '{0, 1, 0, 1, 0, 1};
      int ed [6] = '{-100, -100, -50, -50, 0, 0};
      prn_in = 5'd17; doppler_start = -16'sd100; doppler_step = 16'sd50; doppler_bins = 3;
      code_step = 1; code_max = 1; threshold = 500;
      hit_code = 1; hit_dop = -16'sd50; hit_pwr = 900; def_pwr = 10;
      run_search(-1, dcnt, base);
      prn_in = 5'd3;
      check_seeks("main", base, 6, et, ed);
      check_result("main", dcnt, 1'b1, 900, -16'sd50, 1);
      @(negedge clk);
      checks++;
      if (prn !== 5'd17) begin errors++; $display("FAIL main_prn got %0d want 17", prn); end
   endtask

   task automatic test_ties();
      int dcnt, base;
      int et [6] = '{0, 1, 2, 0, 1, 2};
      int ed [6] = '{300, 300, 300, 280, 280, 280};
      doppler_start = 16'sd300; doppler_step = -16'sd20; doppler_bins = 2;
      code_step = 0; code_max = 2; threshold = 500;
      hit_code = 1; hit_dop = 16'sd280; hit_pwr = 77; def_pwr = 77;
      run_search(-1, dcnt, base);
      check_seeks("ties", base, 6, et, ed);
      check_result("ties", dcnt, 1'b0, 77, 16'sd300, 0);
   endtask

   task automatic test_abort();
      int dcnt;
      doppler_start = 0; doppler_step = 5; doppler_bins = 3; code_step = 1; code_max = 1;
      threshold = 10; def_pwr = 900; hit_pwr = 900; hold_pwr = 1;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      wait_feed(1'b1);
      wait_feed(1'b0);
      abort = 1; m_valid = 1; m_pwr = 900;
      @(negedge clk);
      abort = 0; m_valid = 0;
      checks++;
      if (busy !== 0 || seek_en !== 0 || feed_en !== 0 || done !== 0) begin
         errors++; $display("FAIL abort_next busy/seek/feed/done got %b%b%b%b want 0000", busy, seek_en, feed_en, done);
      end
      checks++;
      if (mode !== MODE_TRACK) begin errors++; $display("FAIL abort_mode got %0d want %0d", mode, MODE_TRACK); end
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      hold_pwr = 0;
      checks++;
      if (dcnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dcnt); end
      checks++;
      if (best_power !== 0 || found !== 0) begin
         errors++; $display("FAIL abort_status best_power=%0d found=%b want 0/0", best_power, found);
      end
   endtask

   task automatic test_code_wrap();
      int dcnt, base;
      int et [6] = '{0, 1000, 2000, 0, 1000, 2000};
      int ed [6] = '{0, 0, 0, 7, 7, 7};
      doppler_start = 0; doppler_step = 7; doppler_bins = 2;
      code_step = 1000; code_max = 2046; threshold = 40;
      hit_code = 2000; hit_dop = 7; hit_pwr = 50; def_pwr = 10;
      run_search(5, dcnt, base);   // second start mid-search is ignored
      check_seeks("wrap", base, 6, et, ed);
      check_result("wrap", dcnt, 1'b1, 50, 7, 2000);
   endtask

   task automatic test_reset_mid();
      int dcnt, base;
      int et [6] = '{0, 1, 0, 0, 0, 0};
      int ed [6] = '{-8, -8, 0, 0, 0, 0};
      prn_in = 9; doppler_start = 40; doppler_step = 3; doppler_bins = 3; code_step = 1; code_max = 1;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      wait_feed(1'b1);
      global_reset = 1;
      @(negedge clk);
      global_reset = 0;
      checks++;
      if (feed_en !== 0 || busy !== 0 || seek_en !== 0 || done !== 0) begin
         errors++; $display("FAIL rst_mid feed/busy/seek/done got %b%b%b%b want 0000", feed_en, busy, seek_en, done);
      end
      checks++;
      if (mode !== MODE_TRACK) begin errors++; $display("FAIL rst_mid_mode got %0d want %0d", mode, MODE_TRACK); end
      checks++;
      if (prn !== 0 || doppler !== 0 || seek_target !== 0) begin
         errors++; $display("FAIL rst_mid_values prn=%0d dop=%0d st=%0d want 0", prn, doppler, seek_target);
      end
      repeat (15) @(negedge clk);
      doppler_start = -16'sd8; doppler_bins = 1; code_max = 1; threshold = 500;
      hit_code = 0; hit_dop = -16'sd8; hit_pwr = 600; def_pwr = 10;
      run_search(-1, dcnt, base);
      check_seeks("rst_rerun", base, 2, et, ed);
      check_result("rst_rerun", dcnt, 1'b1, 600, -16'sd8, 0);
   endtask

   task automatic test_single_cell();
      int dcnt, base;
      int et [6] = '{0, 0, 0, 0, 0, 0};
      int ed [6] = '{-7, 0, 0, 0, 0, 0};
      doppler_start = -16'sd7; doppler_step = 100; doppler_bins = 0;
      code_step = 5; code_max = 0; threshold = 10;
      hit_code = 3; hit_dop = 0; hit_pwr = 99; def_pwr = 20;
      run_search(-1, dcnt, base);
      check_seeks("single", base, 1, et, ed);
      check_result("single", dcnt, 1'b1, 20, -16'sd7, 0);
   endtask

   initial begin
      global_reset = 1; start = 0; abort = 0; m_valid = 0; m_pwr = '0; hold_pwr = 0;
      prn_in = 0; doppler_start = 0; doppler_step = 0; doppler_bins = 0;
      code_step = 0; code_max = 0; threshold = 0;
      hit_code = 0; hit_dop = 0; hit_pwr = 0; def_pwr = 0;
      test_reset();
      test_main_search();
      test_ties();
      test_abort();
      test_code_wrap();
      test_reset_mid();
      test_single_cell();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acq_search_ctrl.md
ACQ_SEARCH_CTRL -- requirements
Module: acq_search_ctrl

Interface
REQ-001 SHALL provide parameter DW, default 16, width of the signed doppler increment.
REQ-002 SHALL provide parameter CSW, default 11, width of the code-shift target.
REQ-003 SHALL provide parameter I2Q2W, default 32, width of the power values.
REQ-004 SHALL provide parameter BW, default 6, width of the doppler bin count.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port global_reset  in  1  synchronous, active-high reset.
REQ-007 Port start  in  1  single-cycle pulse that begins a search.
REQ-008 Port abort  in  1  single-cycle pulse that cancels a search.
REQ-009 Port prn_in  in  5  satellite to search.
REQ-010 Port doppler_start  in  DW  first bin (signed); doppler_step  in  DW  bin spacing (signed).
REQ-011 Port doppler_bins  in  BW  number of bins, 0 treated as 1.
REQ-012 Port code_step  in  CSW  code increment; code_max  in  CSW  last code target, inclusive.
REQ-013 Port threshold  in  I2Q2W  detection threshold.
REQ-014 Channel side inputs: code_shift CSW, accumulation_complete 1, i2q2_valid 1, i2q2_prompt I2Q2W.
REQ-015 Channel side outputs: mode 2, prn 5, doppler DW, seek_en 1, seek_target CSW, feed_en 1.
REQ-016 Status outputs: busy 1, done 1 (pulse), found 1, best_power I2Q2W, best_doppler DW, best_code CSW.

Function
REQ-017 FSM states SHALL be IDLE, SEEK, WAIT_SEEK, ACCUM, WAIT_PWR, ADVANCE, DONE.
REQ-018 IDLE + start SHALL latch prn_in, all search parameters, doppler=doppler_start, code=0, bin=0, best_power=0, found=0, then go to SEEK.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 SEEK SHALL assert seek_en for exactly 1 cycle with seek_target=current code, then go to WAIT_SEEK.
REQ-021 WAIT_SEEK SHALL go to ACCUM in the cycle after code_shift equals current code.
REQ-022 ACCUM SHALL hold feed_en=1 until accumulation_complete=1, then go to WAIT_PWR with feed_en=0.
REQ-023 WAIT_PWR SHALL wait for i2q2_valid; on that cycle, if i2q2_prompt > best_power (strict), it SHALL load best_power, best_doppler=doppler and best_code=code; it then goes to ADVANCE.
REQ-024 Ties SHALL retain the earlier cell.
REQ-025 ADVANCE step 1: if code+code_step > code_max (computed at CSW+1 bits, no wrap), code SHALL reset to 0 and the bin SHALL advance; otherwise code += code_step.
REQ-026 ADVANCE step 2: on bin advance, doppler += doppler_step (two's-complement, wraps at DW).
REQ-027 ADVANCE step 3: if the advanced bin equals the bin count, go to DONE; otherwise go to SEEK.
REQ-028 code_step=0 SHALL be treated as 1.
REQ-029 DONE SHALL assert done for 1 cycle and set found=(best_power > threshold), then return to IDLE.
REQ-030 best_* and found SHALL hold until the next start.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 mode SHALL be MODE_ACQ while busy and MODE_TRACK otherwise.
REQ-033 Outputs prn and doppler SHALL hold the latched values.
REQ-034 abort in any non-IDLE state SHALL return the FSM to IDLE next cycle, drop seek_en and feed_en, suppress done, and leave found=0; abort SHALL take priority over a simultaneous i2q2_valid or accumulation_complete.
REQ-035 accumulation_complete or i2q2_valid received outside its waiting state SHALL be ignored.

Reset
REQ-036 global_reset SHALL take priority over abort and start.
REQ-037 global_reset SHALL force IDLE and clear busy, done, found, seek_en, feed_en, seek_target, best_power, best_doppler, best_code, doppler, prn and mode to MODE_TRACK, all registered, next rising edge, including mid-search.

Verification
REQ-038 Stimulus: doppler_start=-100, step=50, bins=3, code_step=1, code_max=1, model inserts power 900 at (code 1, bin 1), other cells 10, threshold=500 -> required: 6 seek_en pulses in order targets 0,1,0,1,0,1 and doppler -100,-100,-50,-50,0,0; one done pulse; found=1; best_power=900; best_doppler=-50; best_code=1.
REQ-039 Stimulus: equal power 77 in every cell -> required: best_code=0, best_doppler=doppler_start.
REQ-040 Stimulus: abort issued in WAIT_PWR with i2q2_valid high in the same cycle -> required: busy=0 next cycle, no done pulse, best_power unchanged at 0.
REQ-041 Stimulus: code_max=2046, code_step=1000 -> required: code targets 0,1000,2000 then wrap to 0 with a bin advance; no wrap beyond code_max.
REQ-042 Stimulus: global_reset asserted during ACCUM -> required: feed_en=0, busy=0, mode=MODE_TRACK next cycle; a subsequent start runs a full search normally.
REQ-043 Stimulus: bins=0, code_max=0 -> required: exactly one cell is searched, then done.
